// File: rtl/imem_fetch_port.sv
// Clocked instruction store with a valid/ready fetch port, programmable wait states,
// a program-load write port and fetch flush. Bad addresses answer with NOP and an error flag.
module imem_fetch_port #(
  parameter int                DATA_W      = 32,
  parameter int                DEPTH       = 256,
  parameter int                VALID_WORDS = 100,
  parameter int                LATENCY     = 0,
  parameter logic [DATA_W-1:0] NOP         = DATA_W'(32'h00000013),
  parameter string             INIT_FILE   = "./mem/imem2.hex",
  localparam int               IDX_W       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              flush,
  input  logic              prog_we,
  input  logic [IDX_W-1:0]  prog_addr,
  input  logic [DATA_W-1:0] prog_data
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [32:0] ADDR_LIMIT   = 33'(4 * VALID_WORDS);
  localparam logic [3:0]  LOAD_CNT     = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam state_t      ACCEPT_STATE = (LATENCY > 0) ? S_WAIT : S_RESP;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic [DATA_W-1:0] rsp_data_reg;
  logic              rsp_err_reg;

  logic              accept;
  logic              fetch_err;
  logic [DATA_W-1:0] fetch_data;

  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_data;
  end

  assign req_ready = rst_n && !flush &&
                     (state_reg == S_IDLE || (state_reg == S_RESP && rsp_ready));
  assign accept    = req_valid && req_ready;

  // Range check uses the full address, so only in-range words ever reach the array index.
  assign fetch_err  = (req_addr[1:0] != 2'b00) || ({1'b0, req_addr} >= ADDR_LIMIT);
  assign fetch_data = fetch_err ? NOP : mem[req_addr[IDX_W+1:2]];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next = ACCEPT_STATE;
          cnt_next   = LOAD_CNT;
        end
      end
      S_WAIT: begin
        if (cnt_reg == 4'd0) state_next = S_RESP;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      S_RESP: begin
        if (rsp_ready) begin
          if (accept) begin
            state_next = ACCEPT_STATE;
            cnt_next   = LOAD_CNT;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (flush) begin
      state_next = S_IDLE;
      cnt_next   = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Response is captured at accept, so later program writes cannot disturb it (read-first).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_reg <= NOP;
      rsp_err_reg  <= 1'b0;
    end else if (accept) begin
      rsp_data_reg <= fetch_data;
      rsp_err_reg  <= fetch_err;
    end
  end

  assign rsp_valid = (state_reg == S_RESP);
  assign rsp_data  = rsp_data_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_imem_fetch_port.sv
// Directed bench: one fetch port with zero wait states and one with three,
// sharing clock, reset, flush and the program-load port.
module tb_imem_fetch_port;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n, flush, prog_we;
  logic [7:0]  prog_addr;
  logic [31:0] prog_data;

  logic        a_valid, a_ready, a_rvalid, a_rready, a_err;
  logic [31:0] a_addr, a_data;
  logic        b_valid, b_ready, b_rvalid, b_rready, b_err;
  logic [31:0] b_addr, b_data;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  imem_fetch_port #(.LATENCY(0), .INIT_FILE("")) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_ready(a_ready), .req_addr(a_addr),
    .rsp_valid(a_rvalid), .rsp_ready(a_rready), .rsp_data(a_data), .rsp_err(a_err),
    .flush(flush), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data));

  imem_fetch_port #(.LATENCY(3), .INIT_FILE("")) u3 (
    .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready), .req_addr(b_addr),
    .rsp_valid(b_rvalid), .rsp_ready(b_rready), .rsp_data(b_data), .rsp_err(b_err),
    .flush(flush), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data));

  function automatic logic [31:0] img(input int i);
    return 32'hC0DE0000 | 32'(i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic [31:0] d, input logic e,
                         input logic [31:0] xd, input logic xe);
    chk({tag, ".valid"}, 32'(v), 32'd1);
    chk({tag, ".data"}, d, xd);
    chk({tag, ".err"}, 32'(e), 32'(xe));
    $display("rsp %s data=%08h err=%0b", tag, d, e);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    a_valid = 1'b0; a_addr = '0; a_rready = 1'b0;
    b_valid = 1'b0; b_addr = '0; b_rready = 1'b0;

    // Preload the image through the program port while the fetch side is in reset.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      prog_we = 1'b1; prog_addr = 8'(i); prog_data = img(i);
    end
    @(negedge clk);
    prog_we = 1'b0;
    chk("rst.a_rvalid", 32'(a_rvalid), 32'd0);
    chk("rst.a_data", a_data, NOP);
    chk("rst.a_err", 32'(a_err), 32'd0);
    chk("rst.a_ready", 32'(a_ready), 32'd0);
    chk("rst.b_rvalid", 32'(b_rvalid), 32'd0);
    chk("rst.b_data", b_data, NOP);
    rst_n = 1'b1;
    #1 chk("post_rst.a_ready", 32'(a_ready), 32'd1);

    // Zero-latency back-to-back fetches, including error cases.
    a_valid = 1'b1; a_addr = 32'h0; a_rready = 1'b1;
    @(negedge clk); chk_rsp("f0", a_rvalid, a_data, a_err, img(0), 1'b0);  a_addr = 32'h4;
    @(negedge clk); chk_rsp("f4", a_rvalid, a_data, a_err, img(1), 1'b0);  a_addr = 32'h8;
    @(negedge clk); chk_rsp("f8", a_rvalid, a_data, a_err, img(2), 1'b0);  a_addr = 32'h190;
    @(negedge clk); chk_rsp("f190", a_rvalid, a_data, a_err, NOP, 1'b1);   a_addr = 32'h6;
    @(negedge clk); chk_rsp("f6", a_rvalid, a_data, a_err, NOP, 1'b1);     a_addr = 32'h18C;
    @(negedge clk); chk_rsp("f18c", a_rvalid, a_data, a_err, img(99), 1'b0); a_valid = 1'b0;
    @(negedge clk); chk("a_idle.rvalid", 32'(a_rvalid), 32'd0);

    // Three wait states, then a five-cycle stall with a competing request.
    b_valid = 1'b1; b_addr = 32'h10; b_rready = 1'b0;
    #1 chk("b_accept.ready", 32'(b_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); b_valid = 1'b0;
      chk("b_wait.rvalid", 32'(b_rvalid), 32'd0);
      chk("b_wait.ready", 32'(b_ready), 32'd0);
    end
    b_valid = 1'b1; b_addr = 32'h20;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk_rsp("stall", b_rvalid, b_data, b_err, img(4), 1'b0);
      chk("stall.ready", 32'(b_ready), 32'd0);
    end
    b_rready = 1'b1;
    #1 chk("stall_release.ready", 32'(b_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); b_valid = 1'b0;
      chk("b2_wait.rvalid", 32'(b_rvalid), 32'd0);
    end
    @(negedge clk); chk_rsp("b20", b_rvalid, b_data, b_err, img(8), 1'b0);
    @(negedge clk); chk("b_idle.rvalid", 32'(b_rvalid), 32'd0);

    // Program-port visibility and read-first on a same-edge write.
    prog_we = 1'b1; prog_addr = 8'd5; prog_data = 32'hDEADBEEF;
    @(negedge clk);
    prog_we = 1'b0; a_valid = 1'b1; a_addr = 32'h14; a_rready = 1'b1;
    @(negedge clk); chk_rsp("prog14", a_rvalid, a_data, a_err, 32'hDEADBEEF, 1'b0);
    a_addr = 32'h18; prog_we = 1'b1; prog_addr = 8'd6; prog_data = 32'h12345678;
    @(negedge clk); chk_rsp("rdfirst18", a_rvalid, a_data, a_err, img(6), 1'b0);
    prog_we = 1'b0;
    @(negedge clk); chk_rsp("new18", a_rvalid, a_data, a_err, 32'h12345678, 1'b0);
    a_valid = 1'b0;
    @(negedge clk);

    // Flush while waiting: nothing may ever be delivered.
    b_valid = 1'b1; b_addr = 32'h0C; b_rready = 1'b1;
    @(negedge clk); b_valid = 1'b0; flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("flush_wait.rvalid", 32'(b_rvalid), 32'd0);
      @(negedge clk);
    end

    // Flush while responding, with a request held across the flush cycle.
    b_valid = 1'b1; b_addr = 32'h0C; b_rready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); b_valid = 1'b0;
    end
    chk_rsp("pre_flush", b_rvalid, b_data, b_err, img(3), 1'b0);
    flush = 1'b1; b_valid = 1'b1; b_addr = 32'h1C;
    #1 chk("flush.ready", 32'(b_ready), 32'd0);
    @(negedge clk);
    chk("flush_resp.rvalid", 32'(b_rvalid), 32'd0);
    flush = 1'b0;
    #1 chk("after_flush.ready", 32'(b_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); b_valid = 1'b0; b_rready = 1'b1;
      chk("held_req.rvalid", 32'(b_rvalid), 32'd0);
    end
    @(negedge clk); chk_rsp("held1c", b_rvalid, b_data, b_err, img(7), 1'b0);
    @(negedge clk);

    // Asynchronous reset between edges, with u3 waiting and u0 holding a response.
    b_valid = 1'b1; b_addr = 32'h24; b_rready = 1'b1;
    a_valid = 1'b1; a_addr = 32'h20; a_rready = 1'b0;
    @(negedge clk); b_valid = 1'b0; a_valid = 1'b0;
    chk_rsp("pre_rst", a_rvalid, a_data, a_err, img(8), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.a_rvalid", 32'(a_rvalid), 32'd0);
    chk("arst.a_data", a_data, NOP);
    chk("arst.b_rvalid", 32'(b_rvalid), 32'd0);
    chk("arst.b_ready", 32'(b_ready), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    b_valid = 1'b1; b_addr = 32'h28;
    a_valid = 1'b1; a_addr = 32'h14; a_rready = 1'b1;
    @(negedge clk); b_valid = 1'b0; a_valid = 1'b0;
    chk_rsp("post_arst_a", a_rvalid, a_data, a_err, 32'hDEADBEEF, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); chk("post_arst.b_rvalid", 32'(b_rvalid), 32'd0);
    end
    @(negedge clk); chk_rsp("post_arst_b", b_rvalid, b_data, b_err, img(10), 1'b0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
